// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI responder core: register map, status layout, idle byte.
package spi_slave_pkg;

  // Register word offsets (addr[1:0]).
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Status register bit positions; rx_data occupies [7:0].
  localparam int unsigned ST_RX_VALID = 8;
  localparam int unsigned ST_TX_FULL  = 9;
  localparam int unsigned ST_OVERRUN  = 10;
  localparam int unsigned ST_BUSY     = 11;

  // CTRL write bits.
  localparam int unsigned CTRL_CLR_RX_VALID = 0;
  localparam int unsigned CTRL_CLR_OVERRUN  = 1;

  // Byte shifted out when nothing is queued for transmission.
  localparam logic [7:0] DUMMY_DEFAULT = 8'hFF;

  // Assemble the status word.
  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       overrun,
                                              input logic       tx_full,
                                              input logic       rx_valid,
                                              input logic [7:0] rx_data);
    logic [31:0] s;
    s = '0;
    s[ST_BUSY]     = busy;
    s[ST_OVERRUN]  = overrun;
    s[ST_TX_FULL]  = tx_full;
    s[ST_RX_VALID] = rx_valid;
    s[7:0]         = rx_data;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with registered level and
// single-cycle rise/fall pulses that are mutually aligned.
module spi_slave_sync_edge import spi_slave_pkg::*; #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronizer chain, delayed copy and edge pulses; level and pulses update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[STAGES-1] & dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// Memory-mapped SPI responder (modes 0 and 3, MSB first, 8-bit frames).
// SPI pins are oversampled in the clk domain; f_sclk must not exceed f_clk/8.
module spi_slave_core import spi_slave_pkg::*; #(
  parameter logic [7:0]  DUMMY       = DUMMY_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_n_lvl, ss_n_rise, ss_n_fall;
  logic sel;

  spi_slave_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .d_i     (spi_sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // ss_n idles high so reset does not fake a frame start.
  spi_slave_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_ss_n (
    .clk     (clk),
    .reset   (reset),
    .d_i     (spi_ss_n),
    .level_o (ss_n_lvl),
    .rise_o  (ss_n_rise),
    .fall_o  (ss_n_fall)
  );

  assign sel = ~ss_n_lvl;

  // mosi needs no edge detect; one extra stage lines it up with the sclk pulses.
  logic [SYNC_STAGES:0] mosi_sync_q;
  logic                 mosi_s;

  // mosi synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], spi_mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES];

  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;

  logic wr_tx, wr_ctrl, clr_rx_valid, clr_overrun;
  logic load_tx, byte_done;

  assign wr_tx        = cs & write & (addr[1:0] == REG_TXDATA);
  assign wr_ctrl      = cs & write & (addr[1:0] == REG_CTRL);
  assign clr_rx_valid = wr_ctrl & wr_data[CTRL_CLR_RX_VALID];
  assign clr_overrun  = wr_ctrl & wr_data[CTRL_CLR_OVERRUN];

  // Next state for framing, shifters and register file.
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    load_tx    = 1'b0;
    byte_done  = 1'b0;

    if (ss_n_fall) begin
      bit_cnt_d = '0;
      load_tx   = 1'b1;
    end else if (ss_n_rise) begin
      // Partial byte is simply dropped.
      bit_cnt_d = '0;
    end else if (sel) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        if (bit_cnt_q == 3'd7) begin
          byte_done = 1'b1;
          bit_cnt_d = '0;
          load_tx   = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        // bit_cnt == 0 marks the mode-3 leading edge or the post-byte mode-0 edge.
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end

    // The shifter takes the buffer as it was before any same-cycle write.
    if (load_tx) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = DUMMY;
      end
    end

    if (wr_tx) begin
      tx_buf_d  = wr_data[7:0];
      tx_full_d = 1'b1;
    end

    if (clr_rx_valid) rx_valid_d = 1'b0;
    if (clr_overrun)  overrun_d  = 1'b0;

    // A completing byte wins over a same-cycle clear and does not count as overrun then.
    if (byte_done) begin
      rx_data_d  = {rx_shift_q[6:0], mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !clr_rx_valid) overrun_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift_q <= DUMMY;
      rx_shift_q <= DUMMY;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
    end
  end

  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = sel;

  // Side-effect-free read mux.
  always_comb begin
    rd_data = '0;
    unique case (addr[1:0])
      REG_STATUS: rd_data = pack_status(sel, overrun_q, tx_full_q, rx_valid_q, rx_data_q);
      default:    rd_data = '0;
    endcase
  end

  // Inputs that carry no information for this slot.
  logic unused_inputs;
  assign unused_inputs = ^{read, addr[4:2], wr_data[31:8], sclk_lvl};

endmodule
